// File: rtl/laundry_fill_arbiter.sv
// laundry_fill_arbiter: round-robin arbiter sharing one water inlet among four washers.
// Optional fill watchdog (per-machine timeout fault) is enabled by defining FILL_TIMEOUT_EN.

module laundry_fill_arbiter #(
  parameter int SWITCH_GAP   = 2,
  parameter int FILL_TIMEOUT = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_fill_req,
  input  logic [3:0] i_filled,
  output logic [3:0] o_grant,
  output logic       o_inlet_on,
  output logic       o_busy,
  output logic [3:0] o_fault
);

  typedef enum logic [1:0] {IDLE, FILL, GAP} state_t;

  state_t     r_state, w_nextState;
  logic [3:0] r_grant, w_grantNext;
  logic       r_inletOn, w_inletNext;
  logic       r_busy, w_busyNext;
  logic [1:0] r_lastPtr, r_grantIdx, w_selIdx;
  logic       w_selValid;
  logic [3:0] r_gapCnt;
  logic       r_armed;
  logic [3:0] w_fault, w_eligible;
  logic       w_done, w_timeout;

  if (SWITCH_GAP < 1 || SWITCH_GAP > 15 || FILL_TIMEOUT < 2 || FILL_TIMEOUT > 65535) begin : g_badCfg
    $error("laundry_fill_arbiter: SWITCH_GAP or FILL_TIMEOUT out of range");
  end

  assign w_eligible = i_fill_req & ~i_filled & ~w_fault;
  assign w_done     = i_filled[r_grantIdx] | ~i_fill_req[r_grantIdx];

  // Walk the offsets downward so the nearest eligible index after r_lastPtr is the last one written.
  always_comb begin
    w_selValid = 1'b0;
    w_selIdx   = r_lastPtr;
    for (int k = 4; k >= 1; k--) begin
      if (w_eligible[r_lastPtr + 2'(k)]) begin
        w_selValid = 1'b1;
        w_selIdx   = r_lastPtr + 2'(k);
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (r_armed && w_selValid) w_nextState = FILL;
      FILL:    if (w_done || w_timeout)   w_nextState = GAP;
      GAP:     if (r_gapCnt == 4'd0)      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_grantNext = 4'b0000;
    w_inletNext = 1'b0;
    w_busyNext  = (w_nextState != IDLE);
    if (w_nextState == FILL) begin
      w_inletNext = 1'b1;
      w_grantNext = (r_state == IDLE) ? (4'b0001 << w_selIdx) : r_grant;
    end
  end

  // r_armed holds off arbitration for one cycle after reset releases.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_grant    <= 4'b0000;
      r_inletOn  <= 1'b0;
      r_busy     <= 1'b0;
      r_lastPtr  <= 2'd3;
      r_grantIdx <= 2'd0;
      r_gapCnt   <= 4'd0;
      r_armed    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_grant   <= w_grantNext;
      r_inletOn <= w_inletNext;
      r_busy    <= w_busyNext;
      r_armed   <= 1'b1;
      if (r_state == IDLE && w_nextState == FILL) begin
        r_lastPtr  <= w_selIdx;
        r_grantIdx <= w_selIdx;
      end
      if (r_state == FILL && w_nextState == GAP) begin
        r_gapCnt <= 4'(SWITCH_GAP - 1);
      end else if (r_state == GAP) begin
        r_gapCnt <= r_gapCnt - 4'd1;
      end
    end
  end

`ifdef FILL_TIMEOUT_EN
  logic [15:0] r_fillCnt;
  logic [3:0]  r_fault;

  // A genuine fill completion in the timeout cycle wins over the watchdog.
  assign w_timeout = (r_state == FILL) && !w_done && (r_fillCnt == 16'(FILL_TIMEOUT - 1));
  assign w_fault   = r_fault;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fillCnt <= 16'd0;
      r_fault   <= 4'b0000;
    end else begin
      r_fillCnt <= (r_state == FILL && w_nextState == FILL) ? r_fillCnt + 16'd1 : 16'd0;
      r_fault   <= (r_fault & i_fill_req) | (w_timeout ? (4'b0001 << r_grantIdx) : 4'b0000);
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_fault   = 4'b0000;
`endif

  assign o_grant    = r_grant;
  assign o_inlet_on = r_inletOn;
  assign o_busy     = r_busy;
  assign o_fault    = w_fault;

endmodule

// File: tb/tb_laundry_fill_arbiter.sv
// tb_laundry_fill_arbiter: scenario and randomized checks of laundry_fill_arbiter against a
// behavioural model of the arbitration rules; the watchdog scenario runs only with FILL_TIMEOUT_EN.

module tb_laundry_fill_arbiter;

  localparam int SWITCH_GAP   = 2;
  localparam int FILL_TIMEOUT = 10;
`ifdef FILL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fillReq = 4'b0000;
  logic [3:0] filled = 4'b0000;
  logic [3:0] o_grant, o_fault;
  logic       o_inlet_on, o_busy;
  logic [9:0] dutVec;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  laundry_fill_arbiter #(.SWITCH_GAP(SWITCH_GAP), .FILL_TIMEOUT(FILL_TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset), .i_fill_req(fillReq), .i_filled(filled),
    .o_grant(o_grant), .o_inlet_on(o_inlet_on), .o_busy(o_busy), .o_fault(o_fault)
  );

  assign dutVec = {o_grant, o_inlet_on, o_busy, o_fault};

  // Reference model: which machine holds the inlet (-1 = none), how many changeover
  // cycles remain, and whether the first post-reset cycle is still being waited out.
  int         mGrant = -1;
  int         mGapLeft = 0;
  bit         mHold = 1'b1;
  int         mLast = 3;
  int         mCount = 0;
  logic [3:0] mFault = 4'b0000;
  logic [3:0] mSet;

  always @(posedge clk) begin
    if (reset) begin
      mGrant = -1; mGapLeft = 0; mHold = 1'b1; mLast = 3; mCount = 0; mFault = 4'b0000;
    end else begin
      mSet = 4'b0000;
      if (mGrant >= 0) begin
        if (filled[mGrant] || !fillReq[mGrant]) begin
          mGrant = -1; mGapLeft = SWITCH_GAP;
        end else if (TIMEOUT_EN && mCount == FILL_TIMEOUT - 1) begin
          mSet[mGrant] = 1'b1; mGrant = -1; mGapLeft = SWITCH_GAP;
        end else begin
          mCount++;
        end
      end else if (mGapLeft > 0) begin
        mGapLeft--;
      end else if (!mHold) begin
        for (int k = 1; k <= 4; k++) begin
          if (mGrant < 0 && fillReq[(mLast + k) % 4] && !filled[(mLast + k) % 4] && !mFault[(mLast + k) % 4])
            mGrant = (mLast + k) % 4;
        end
        if (mGrant >= 0) begin
          mLast = mGrant; mCount = 0;
        end
      end
      mHold = 1'b0;
      mFault = (mFault & fillReq) | mSet;
    end
  end

  function automatic logic [9:0] expVec();
    logic [3:0] g;
    g = (mGrant >= 0) ? 4'(1 << mGrant) : 4'b0000;
    return {g, mGrant >= 0, (mGrant >= 0) || (mGapLeft > 0), mFault};
  endfunction

  task automatic test_reset();
    reset = 1'b1; fillReq = 4'b0000; filled = 4'b0000;
    repeat (3) @(negedge clk);
    testsRun++;
    if (dutVec !== 10'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state got %b want %b", dutVec, 10'b0);
    end
    reset = 1'b0; fillReq = 4'b0001;
    @(negedge clk);
    testsRun++;
    if (o_grant !== 4'b0000 || dutVec !== expVec()) begin
      testsFailed++;
      $display("[TB] FAIL reset_holdoff got %b want %b", dutVec, expVec());
    end
  endtask

  task automatic test_single();
    int gc = 0;
    int gapc = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      testsRun++;
      if (dutVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL single cyc%0d got %b want %b", i, dutVec, expVec());
      end
      if (o_grant == 4'b0001) begin
        gc++; seen = 1'b1;
      end else if (seen && o_busy) begin
        gapc++;
      end
      if (gc == 7) filled = 4'b0001;
      if (seen && !o_busy) break;
    end
    fillReq = 4'b0000; filled = 4'b0000;
    testsRun++;
    if (gc != 7) begin
      testsFailed++;
      $display("[TB] FAIL single_grant_len got %0d want 7", gc);
    end
    testsRun++;
    if (gapc != SWITCH_GAP) begin
      testsFailed++;
      $display("[TB] FAIL single_gap_len got %0d want %0d", gapc, SWITCH_GAP);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order[$];
    int gaps[$];
    logic [3:0] expOrder[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int held = 0;
    int zeros = 0;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    fillReq = 4'b1111; filled = 4'b0000;
    for (int i = 0; i < 120 && order.size() < 5; i++) begin
      @(negedge clk);
      testsRun++;
      if (dutVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL round_robin cyc%0d got %b want %b", i, dutVec, expVec());
      end
      filled = 4'b0000;
      if (o_grant != 4'b0000) begin
        if (held == 0) begin
          order.push_back(o_grant);
          if (order.size() > 1) gaps.push_back(zeros);
        end
        held++; zeros = 0;
        if (held == 3) begin
          filled = o_grant; held = 0;
        end
      end else begin
        zeros++;
      end
    end
    fillReq = 4'b0000; filled = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      testsRun++;
      if (order.size() <= i || order[i] !== expOrder[i]) begin
        testsFailed++;
        $display("[TB] FAIL rr_order idx%0d got %b want %b", i, (order.size() > i) ? order[i] : 4'bxxxx, expOrder[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (gaps.size() <= i || gaps[i] != SWITCH_GAP + 1) begin
        testsFailed++;
        $display("[TB] FAIL rr_gap idx%0d got %0d want %0d", i, (gaps.size() > i) ? gaps[i] : -1, SWITCH_GAP + 1);
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_prefilled();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    fillReq = 4'b0100; filled = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      testsRun++;
      if (o_grant !== 4'b0000 || o_busy !== 1'b0 || dutVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL prefilled cyc%0d got %b want %b", i, dutVec, expVec());
      end
    end
    fillReq = 4'b0000; filled = 4'b0000;
  endtask

  task automatic test_reset_mid_fill();
    int gc = 0;
    logic [3:0] first = 4'b0000;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    fillReq = 4'b0100;
    for (int i = 0; i < 20 && gc < 4; i++) begin
      @(negedge clk);
      if (o_grant == 4'b0100) gc++;
    end
    testsRun++;
    if (gc != 4) begin
      testsFailed++;
      $display("[TB] FAIL midfill_grant got %0d cycles want 4", gc);
    end
    reset = 1'b1;
    @(negedge clk);
    testsRun++;
    if (o_grant !== 4'b0000 || o_inlet_on !== 1'b0 || o_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midfill_abort got %b want %b", dutVec, 10'b0);
    end
    reset = 1'b0; fillReq = 4'b0101;
    for (int i = 0; i < 10 && first == 4'b0000; i++) begin
      @(negedge clk);
      first = o_grant;
    end
    testsRun++;
    if (first !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL midfill_first got %b want 0001", first);
    end
    fillReq = 4'b0000;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_drop();
    int gc = 0;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    fillReq = 4'b1001;
    for (int i = 0; i < 20 && gc < 3; i++) begin
      @(negedge clk);
      if (o_grant == 4'b0001) gc++;
    end
    fillReq = 4'b1000;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      testsRun++;
      if (o_grant !== ((n == 4) ? 4'b1000 : 4'b0000) || dutVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL drop n%0d got %b want %b", n, dutVec, expVec());
      end
    end
    fillReq = 4'b0000;
    repeat (6) @(negedge clk);
  endtask

`ifdef FILL_TIMEOUT_EN
  task automatic test_timeout();
    int gc = 0;
    bit regranted = 1'b0;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    fillReq = 4'b0010; filled = 4'b0000;
    for (int i = 0; i < 40 && o_fault == 4'b0000; i++) begin
      @(negedge clk);
      if (o_grant == 4'b0010) gc++;
    end
    testsRun++;
    if (gc != FILL_TIMEOUT || o_fault !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL timeout_len got %0d cycles fault %b want %0d fault 0010", gc, o_fault, FILL_TIMEOUT);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      testsRun++;
      if (o_grant !== 4'b0000 || dutVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL timeout_nogrant cyc%0d got %b want %b", i, dutVec, expVec());
      end
    end
    fillReq = 4'b0000;
    @(negedge clk);
    testsRun++;
    if (o_fault !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL timeout_clear got %b want 0000", o_fault);
    end
    fillReq = 4'b0010;
    for (int i = 0; i < 10 && !regranted; i++) begin
      @(negedge clk);
      regranted = (o_grant == 4'b0010);
    end
    testsRun++;
    if (!regranted) begin
      testsFailed++;
      $display("[TB] FAIL timeout_regrant got %b want 0010", o_grant);
    end
    fillReq = 4'b0000;
    repeat (6) @(negedge clk);
  endtask
`endif

  task automatic test_random();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      testsRun++;
      if (dutVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL random cyc%0d got %b want %b", i, dutVec, expVec());
      end
      if ($urandom_range(0, 3) == 0) fillReq = 4'($urandom);
      filled = 4'($urandom & $urandom & $urandom);
      reset = ($urandom_range(0, 80) == 0);
    end
    reset = 1'b0; fillReq = 4'b0000; filled = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_prefilled();
    test_reset_mid_fill();
    test_drop();
`ifdef FILL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/laundry_fill_arbiter.md
LAUNDRY_FILL_ARBITER -- requirements
Module: laundry_fill_arbiter

Interface
REQ-001 Parameters SHALL be: SWITCH_GAP, default 2, dead cycles between successive grants for valve changeover (range 1-15); FILL_TIMEOUT, default 1000, maximum FILL cycles per grant (range 2-65535).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fill_req  input  4  per-machine fill request; bit i is machine i's fill valve command.
REQ-005 filled  input  4  per-machine level sensor; bit i high means machine i is full.
REQ-006 grant  output  4  one-hot or zero; bit i opens machine i's branch valve.
REQ-007 inlet_on  output  1  main supply valve; high only while a grant is active.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 fault  output  4  per-machine fill-timeout flag.
REQ-010 All outputs SHALL be driven from registers, with no combinational input-to-output path.

Function
REQ-011 Machine i SHALL be eligible when fill_req[i]=1, filled[i]=0 and fault[i]=0.
REQ-012 The FSM SHALL have exactly three states: IDLE, FILL and GAP.
REQ-013 In IDLE with at least one eligible machine, the block SHALL select the first eligible index searching upward, with wrap-around, from last_ptr+1, and SHALL enter FILL.
REQ-014 On entering FILL, grant SHALL show the selected one-hot bit in the cycle after the eligibility was sampled.
REQ-015 On entering FILL, inlet_on SHALL go high in that same cycle, and last_ptr SHALL update to the selected index.
REQ-016 In FILL, grant SHALL be held and the 16-bit fill counter SHALL increment every cycle, starting from 0.
REQ-017 FILL SHALL end when filled[g]=1 or fill_req[g]=0 for the granted index g; grant and inlet_on SHALL be 0 the following cycle and the state SHALL be GAP.
REQ-018 Requests from non-granted machines SHALL NOT pre-empt an active grant.
REQ-019 GAP SHALL last exactly SWITCH_GAP cycles with grant=0 and inlet_on=0, then return to IDLE.
REQ-020 Back-to-back grants SHALL therefore be separated by SWITCH_GAP+1 cycles of grant=0: SWITCH_GAP cycles in GAP and 1 cycle in IDLE.
REQ-021 If filled[g] and the timeout condition occur in the same cycle, filled SHALL take priority and fault[g] SHALL NOT be set.
REQ-022 A machine with filled[i]=1 at request time SHALL never be granted.
REQ-023 In IDLE with no eligible machine, outputs SHALL remain 0 and last_ptr SHALL be unchanged.

Reset
REQ-024 While reset=1 at a clock edge, the block SHALL enter IDLE with grant=0, inlet_on=0, busy=0, fault=0 and fill counter=0.
REQ-025 While reset=1 at a clock edge, last_ptr SHALL be set to 3, so machine 0 has first priority after reset.
REQ-026 Reset asserted mid-FILL or mid-GAP SHALL abort the operation at that edge, with no GAP sequence.
REQ-027 The first grant after reset deasserts SHALL occur no earlier than 2 cycles after that deassertion.

Configuration
REQ-028 The macro FILL_TIMEOUT_EN SHALL control the fill watchdog.
REQ-029 With FILL_TIMEOUT_EN defined, FILL reaching count FILL_TIMEOUT-1 without filled[g] SHALL set fault[g] and move to GAP the next cycle.
REQ-030 With FILL_TIMEOUT_EN defined, fault[i] SHALL clear on the cycle after fill_req[i] is sampled low.
REQ-031 With FILL_TIMEOUT_EN undefined, fault SHALL be constant 0, FILL SHALL end only per REQ-017, and no fill counter logic SHALL be synthesised.

Verification
REQ-032 Scenario: reset, then fill_req=4'b0001 and filled[0]=1 seven cycles after grant -> grant=0001 for 7 cycles; inlet_on follows grant; then 2 GAP cycles and busy=0.
REQ-033 Scenario: fill_req=4'b1111 held, each filled[i] pulsed after 3 grant cycles -> grant order 0001,0010,0100,1000, then 0001 again; 3 zero cycles between grants.
REQ-034 Scenario: fill_req=4'b0100 with filled=4'b0100 already high -> grant stays 0000 and busy stays 0.
REQ-035 Scenario (FILL_TIMEOUT_EN, FILL_TIMEOUT=10): fill_req[1]=1 and filled never rises -> grant=0010 for 10 cycles, then fault=0010; machine 1 is not regranted until fill_req[1] toggles 0 then 1.
REQ-036 Scenario: reset=1 applied on the 4th FILL cycle of machine 2 -> next cycle grant=0, inlet_on=0, busy=0; then with fill_req=4'b0101, machine 0 is granted first.
REQ-037 Scenario: fill_req[g] dropped mid-FILL while fill_req[3] is high -> grant clears next cycle, and 3 cycles later grant=1000.
